// File: rtl/lights_sequencer.sv
// Start-lights sequencer: fills a light bar one step at a time, holds for a
// pseudo-random delay, then enables a reaction counter until the key is pressed.
module lights_sequencer #(
  parameter int unsigned N_LIGHTS   = 10,
  parameter int unsigned STEP_TICKS = 500,
  parameter int unsigned DELAY_UNIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                trigger,
  input  logic                press_key,
  output logic [N_LIGHTS-1:0] lights,
  output logic                enable,
  output logic                jump_start,
  output logic                busy
);

  localparam int unsigned MAX_HOLD  = 127 * DELAY_UNIT;
  localparam int unsigned MAX_TICKS = (STEP_TICKS > MAX_HOLD) ? STEP_TICKS : MAX_HOLD;
  localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_TICKS - 1);

  // RUN owns state[2] alone so enable comes straight off one flop.
  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_FILL = 3'b001,
    S_HOLD = 3'b010,
    S_DONE = 3'b011,
    S_RUN  = 3'b100
  } state_t;

  state_t              state;
  logic [6:0]          lfsr;
  logic [CNT_W-1:0]    tick_cnt;
  logic [CNT_W-1:0]    hold_last;
  logic [N_LIGHTS-1:0] lights_next;

  assign lights_next = N_LIGHTS'({lights, 1'b1});
  assign enable      = state[2];
  assign busy        = (state == S_FILL) || (state == S_HOLD) || (state == S_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      lfsr       <= 7'h01;
      tick_cnt   <= '0;
      hold_last  <= '0;
      lights     <= '0;
      jump_start <= 1'b0;
    end else begin
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      unique case (state)
        S_IDLE, S_DONE: begin
          if (trigger) begin
            state      <= S_FILL;
            lights     <= '0;
            jump_start <= 1'b0;
            tick_cnt   <= '0;
          end
        end
        S_FILL: begin
          if (press_key) begin
            state      <= S_DONE;
            lights     <= '0;
            jump_start <= 1'b1;
          end else if (tick) begin
            if (tick_cnt == STEP_LAST) begin
              tick_cnt <= '0;
              lights   <= lights_next;
              if (lights_next[N_LIGHTS-1]) begin
                state     <= S_HOLD;
                hold_last <= CNT_W'(32'(lfsr) * DELAY_UNIT - 32'd1);
              end
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (press_key) begin
            state      <= S_DONE;
            lights     <= '0;
            jump_start <= 1'b1;
          end else if (tick) begin
            if (tick_cnt == hold_last) begin
              tick_cnt <= '0;
              lights   <= '0;
              state    <= S_RUN;
            end else begin
              tick_cnt <= tick_cnt + CNT_W'(1);
            end
          end
        end
        S_RUN: begin
          if (press_key) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
